// File: rtl/sram_bridge_pkg.sv
// Shared types for the LSU-to-SRAM bridge: access sizes, sequencer states and default depth.
package sram_bridge_pkg;

  localparam int NWORDS_DEF = 128;

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC0 = 2'd1,
    ST_ACC1 = 2'd2,
    ST_RESP = 2'd3
  } state_e;

endpackage

// File: rtl/sram_bridge_align.sv
// Combinational lane steering: store byte mask/data replication and load lane extract with sign/zero extension.
module sram_bridge_align
  import sram_bridge_pkg::*;
(
  input  size_e       size,
  input  logic [1:0]  lane,
  input  logic        uns,
  input  logic [31:0] wdata,
  input  logic [31:0] q,
  input  logic [31:0] lo,
  output logic [3:0]  wem,
  output logic [31:0] d,
  output logic [63:0] rdata
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = q[{lane, 3'b000} +: 8];
  assign half_sel = lane[1] ? q[31:16] : q[15:0];

  always_comb begin
    wem   = 4'h0;
    d     = 32'h0;
    rdata = 64'h0;
    case (size)
      SZ_B: begin
        wem   = 4'b0001 << lane;
        d     = {4{wdata[7:0]}};
        rdata = {{56{~uns & byte_sel[7]}}, byte_sel};
      end
      SZ_H: begin
        wem   = lane[1] ? 4'b1100 : 4'b0011;
        d     = {2{wdata[15:0]}};
        rdata = {{48{~uns & half_sel[15]}}, half_sel};
      end
      SZ_W: begin
        wem   = 4'hF;
        d     = wdata;
        rdata = {{32{~uns & q[31]}}, q};
      end
      default: begin
        // Doubleword: q carries the high word, lo was captured one access earlier.
        wem   = 4'hF;
        d     = wdata;
        rdata = {q, lo};
      end
    endcase
  end

endmodule

// File: rtl/sram_lsu_bridge.sv
// Sequencer between the LSU and a byte-maskable 32-bit SRAM macro; doublewords take two accesses.
// Define SRAM_BRIDGE_ALIGN_CHECK_EN to flag misaligned requests instead of silently aligning them.
module sram_lsu_bridge
  import sram_bridge_pkg::*;
#(
  parameter  int NWORDS = NWORDS_DEF,
  localparam int AW     = $clog2(NWORDS) + 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [1:0]    req_size,
  input  logic          req_unsigned,
  input  logic [AW-1:0] req_addr,
  input  logic [63:0]   req_wdata,
  output logic          rsp_valid,
  output logic          rsp_err,
  output logic [63:0]   rsp_rdata,
  output logic          sram_me,
  output logic [AW-3:0] sram_adr,
  output logic          sram_we,
  output logic [3:0]    sram_wem,
  output logic [31:0]   sram_d,
  output logic          sram_oe,
  input  logic [31:0]   sram_q
);

  state_e        state, state_n;
  logic          we_q, uns_q, err_q;
  size_e         size_q;
  logic [AW-1:0] addr_q;
  logic [63:0]   wdata_q;
  logic [31:0]   lo_q;
  logic [2:0]    low_mask;
  logic          accept_err;
  logic [3:0]    al_wem;
  logic [31:0]   al_d;
  logic [63:0]   al_rdata;

  always_comb begin
    case (req_size)
      2'd1:    low_mask = 3'b001;
      2'd2:    low_mask = 3'b011;
      2'd3:    low_mask = 3'b111;
      default: low_mask = 3'b000;
    endcase
  end

`ifdef SRAM_BRIDGE_ALIGN_CHECK_EN
  assign accept_err = |(req_addr[2:0] & low_mask);
`else
  assign accept_err = 1'b0;
`endif

  // Request latches; without the check the sub-size address bits are dropped here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      size_q  <= SZ_B;
      addr_q  <= '0;
      wdata_q <= '0;
      lo_q    <= '0;
    end else begin
      state <= state_n;
      if (state == ST_IDLE && req_valid) begin
        we_q    <= req_we;
        uns_q   <= req_unsigned;
        err_q   <= accept_err;
        size_q  <= size_e'(req_size);
        addr_q  <= {req_addr[AW-1:3], req_addr[2:0] & ~low_mask};
        wdata_q <= req_wdata;
      end
      if (state == ST_ACC1) lo_q <= sram_q;
    end
  end

  sram_bridge_align u_align (
    .size  (size_q),
    .lane  (addr_q[1:0]),
    .uns   (uns_q),
    .wdata (wdata_q[31:0]),
    .q     (sram_q),
    .lo    (lo_q),
    .wem   (al_wem),
    .d     (al_d),
    .rdata (al_rdata)
  );

  assign sram_oe = 1'b1;

  always_comb begin
    state_n   = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    rsp_rdata = 64'h0;
    sram_me   = 1'b0;
    sram_adr  = '0;
    sram_we   = 1'b0;
    sram_wem  = 4'h0;
    sram_d    = 32'h0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_n = accept_err ? ST_RESP : ST_ACC0;
      end
      ST_ACC0: begin
        sram_me  = 1'b1;
        sram_adr = addr_q[AW-1:2];
        sram_we  = we_q;
        sram_wem = we_q ? al_wem : 4'h0;
        sram_d   = we_q ? al_d : 32'h0;
        state_n  = (size_q == SZ_D) ? ST_ACC1 : ST_RESP;
      end
      ST_ACC1: begin
        // Doubleword base is 8-byte aligned, so the second word is just bit 0 set.
        sram_me  = 1'b1;
        sram_adr = {addr_q[AW-1:3], 1'b1};
        sram_we  = we_q;
        sram_wem = we_q ? 4'hF : 4'h0;
        sram_d   = we_q ? wdata_q[63:32] : 32'h0;
        state_n  = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        if (!we_q && !err_q) rsp_rdata = al_rdata;
        state_n   = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sram_lsu_bridge.sv
// Self-checking bench for sram_lsu_bridge: behavioural SRAM macro plus a byte-array reference memory.
module tb_sram_lsu_bridge;
  import sram_bridge_pkg::*;

  localparam int NWORDS = 128;
  localparam int AW     = 9;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid, req_ready, req_we, req_unsigned;
  logic [1:0]    req_size;
  logic [AW-1:0] req_addr;
  logic [63:0]   req_wdata;
  logic          rsp_valid, rsp_err;
  logic [63:0]   rsp_rdata;
  logic          sram_me, sram_we, sram_oe;
  logic [AW-3:0] sram_adr;
  logic [3:0]    sram_wem;
  logic [31:0]   sram_d, sram_q;

  logic [31:0] mem     [NWORDS];
  logic [7:0]  ref_mem [NWORDS*4];

  int n_cmp  = 0;
  int n_fail = 0;

  int          lat;
  logic        got_rsp, got_err, seen_me;
  logic [63:0] got_rdata;
  logic [AW-3:0] first_adr;
  logic [3:0]  first_wem;
  logic [31:0] first_d;

  always #5 clk = ~clk;

  sram_lsu_bridge #(.NWORDS(NWORDS)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_rdata(rsp_rdata), .sram_me(sram_me), .sram_adr(sram_adr),
    .sram_we(sram_we), .sram_wem(sram_wem), .sram_d(sram_d),
    .sram_oe(sram_oe), .sram_q(sram_q)
  );

  // Macro model: masked byte writes, registered read data held until the next read.
  always @(posedge clk) begin
    if (sram_me) begin
      if (sram_we) begin
        for (int b = 0; b < 4; b++)
          if (sram_wem[b]) mem[sram_adr][8*b +: 8] <= sram_d[8*b +: 8];
      end else begin
        sram_q <= mem[sram_adr];
      end
    end
  end

  function automatic bit ref_misaligned(input int size, input int addr);
`ifdef SRAM_BRIDGE_ALIGN_CHECK_EN
    return (addr % (1 << size)) != 0;
`else
    return 1'b0;
`endif
  endfunction

  function automatic int ref_eff(input int size, input int addr);
    return addr - (addr % (1 << size));
  endfunction

  function automatic void ref_store(input int size, input int addr, input logic [63:0] wdata);
    int a = ref_eff(size, addr);
    for (int i = 0; i < (1 << size); i++) ref_mem[a+i] = wdata[8*i +: 8];
  endfunction

  function automatic logic [63:0] ref_load(input int size, input int addr, input bit uns);
    int a = ref_eff(size, addr);
    int nbits = 8 * (1 << size);
    logic [63:0] v = 64'h0;
    for (int i = 0; i < (1 << size); i++) v = v | ({56'h0, ref_mem[a+i]} << (8*i));
    if (!uns && size < 3 && v[nbits-1]) v = v | ~((64'h1 << nbits) - 64'h1);
    return v;
  endfunction

  function automatic int ref_latency(input int size, input bit err);
    if (err) return 1;
    return (size == 3) ? 3 : 2;
  endfunction

  // Drives one request, scrambles req_* after accept, and records what the DUT did until the response.
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [AW-1:0] addr, input logic [63:0] wdata);
    int k = 0;
    while (!req_ready && k < 20) begin
      @(posedge clk); #1; k++;
    end
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom);
    req_unsigned = 1'($urandom); req_addr = AW'($urandom);
    req_wdata = {$urandom, $urandom};
    got_rsp = 1'b0; got_err = 1'b0; got_rdata = 64'h0; lat = 0; seen_me = 1'b0;
    first_adr = '0; first_wem = 4'h0; first_d = 32'h0;
    for (int c = 1; c <= 8 && !got_rsp; c++) begin
      if (sram_me && !seen_me) begin
        seen_me = 1'b1; first_adr = sram_adr; first_wem = sram_wem; first_d = sram_d;
      end
      if (rsp_valid) begin
        got_rsp = 1'b1; lat = c; got_err = rsp_err; got_rdata = rsp_rdata;
      end else begin
        @(posedge clk); #1;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid, rsp_err, sram_me, sram_we, sram_oe} !== 6'b100001) begin
      n_fail++;
      $display("[TB] FAIL reset_ctrl got %b want 100001",
               {req_ready, rsp_valid, rsp_err, sram_me, sram_we, sram_oe});
    end
    n_cmp++;
    if ({rsp_rdata, sram_adr, sram_wem, sram_d} !== '0) begin
      n_fail++;
      $display("[TB] FAIL reset_data rdata=%h adr=%h wem=%h d=%h want 0",
               rsp_rdata, sram_adr, sram_wem, sram_d);
    end
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_byte();
    do_req(1'b1, 2'd0, 1'b0, 9'h006, 64'hA5);
    ref_store(0, 6, 64'hA5);
    n_cmp++;
    if ({first_wem, first_d} !== {4'b0100, 32'hA5A5A5A5}) begin
      n_fail++;
      $display("[TB] FAIL sb_steer got wem=%b d=%h want 0100 a5a5a5a5", first_wem, first_d);
    end
    do_req(1'b0, 2'd0, 1'b0, 9'h006, 64'h0);
    n_cmp++;
    if (got_rdata !== 64'hFFFFFFFF_FFFFFFA5 || lat != 2) begin
      n_fail++;
      $display("[TB] FAIL lb got %h lat %0d want ffffffffffffffa5 lat 2", got_rdata, lat);
    end
    do_req(1'b0, 2'd0, 1'b1, 9'h006, 64'h0);
    n_cmp++;
    if (got_rdata !== 64'h00000000_000000A5) begin
      n_fail++;
      $display("[TB] FAIL lbu got %h want a5", got_rdata);
    end
  endtask

  task automatic test_dword();
    do_req(1'b1, 2'd3, 1'b0, 9'h1F8, 64'h11223344_55667788);
    ref_store(3, 'h1F8, 64'h11223344_55667788);
    n_cmp++;
    if (mem[126] !== 32'h55667788 || mem[127] !== 32'h11223344 || lat != 3) begin
      n_fail++;
      $display("[TB] FAIL sd got w126=%h w127=%h lat %0d want 55667788 11223344 lat 3",
               mem[126], mem[127], lat);
    end
    do_req(1'b0, 2'd3, 1'b0, 9'h1F8, 64'h0);
    n_cmp++;
    if (got_rdata !== 64'h11223344_55667788 || lat != 3) begin
      n_fail++;
      $display("[TB] FAIL ld got %h lat %0d want 1122334455667788 lat 3", got_rdata, lat);
    end
  endtask

  task automatic test_word_sign();
    do_req(1'b1, 2'd2, 1'b0, 9'h010, 64'h80000000);
    ref_store(2, 'h10, 64'h80000000);
    do_req(1'b0, 2'd2, 1'b0, 9'h010, 64'h0);
    n_cmp++;
    if (got_rdata !== 64'hFFFFFFFF_80000000) begin
      n_fail++;
      $display("[TB] FAIL lw got %h want ffffffff80000000", got_rdata);
    end
    do_req(1'b0, 2'd2, 1'b1, 9'h010, 64'h0);
    n_cmp++;
    if (got_rdata !== 64'h00000000_80000000) begin
      n_fail++;
      $display("[TB] FAIL lwu got %h want 0000000080000000", got_rdata);
    end
  endtask

  task automatic test_misaligned();
    logic [63:0] exp_rd;
    do_req(1'b0, 2'd1, 1'b0, 9'h003, 64'h0);
`ifdef SRAM_BRIDGE_ALIGN_CHECK_EN
    n_cmp++;
    if (got_err !== 1'b1 || lat != 1 || seen_me !== 1'b0 || got_rdata !== 64'h0) begin
      n_fail++;
      $display("[TB] FAIL lh_misaligned got err=%b lat=%0d me=%b rd=%h want 1 1 0 0",
               got_err, lat, seen_me, got_rdata);
    end
`else
    exp_rd = ref_load(1, 2, 1'b0);
    n_cmp++;
    if (got_err !== 1'b0 || lat != 2 || got_rdata !== exp_rd) begin
      n_fail++;
      $display("[TB] FAIL lh_forced_align got err=%b lat=%0d rd=%h want 0 2 %h",
               got_err, lat, got_rdata, exp_rd);
    end
`endif
  endtask

  task automatic test_reset_mid();
    logic [31:0] old17;
    int k = 0;
    logic saw_rsp = 1'b0;
    old17 = mem[17];
    while (!req_ready && k < 20) begin
      @(posedge clk); #1; k++;
    end
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd3; req_unsigned = 1'b0;
    req_addr = 9'h040; req_wdata = 64'hCAFEBABE_DEADBEEF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    n_cmp++;
    if ({req_ready, rsp_valid, sram_me, sram_we, sram_wem, sram_oe} !== {4'b1000, 4'h0, 1'b1}) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_outputs got rdy=%b v=%b me=%b we=%b wem=%h oe=%b want 1 0 0 0 0 1",
               req_ready, rsp_valid, sram_me, sram_we, sram_wem, sram_oe);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (rsp_valid) saw_rsp = 1'b1;
      @(posedge clk); #1;
    end
    n_cmp++;
    if (saw_rsp !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_no_rsp got rsp_valid seen=%b want 0", saw_rsp);
    end
    n_cmp++;
    if (mem[16] !== 32'hDEADBEEF || mem[17] !== old17) begin
      n_fail++;
      $display("[TB] FAIL mid_reset_words got w16=%h w17=%h want deadbeef %h", mem[16], mem[17], old17);
    end
    ref_store(2, 'h40, 64'hDEADBEEF);
  endtask

  task automatic test_back_to_back();
    int a = 4 * int'($urandom_range(NWORDS - 1, 0));
    logic [63:0] wd = {32'h0, $urandom};
    logic [63:0] exp_rd;
    int k = 0;
    while (!req_ready && k < 20) begin
      @(posedge clk); #1; k++;
    end
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'd2; req_unsigned = 1'b0;
    req_addr = AW'(a); req_wdata = wd;
    ref_store(2, a, wd);
    exp_rd = ref_load(2, a, 1'b0);
    @(posedge clk); #1;
    n_cmp++;
    if (req_ready !== 1'b0 || sram_we !== 1'b1 || sram_adr !== (AW-2)'(a / 4)) begin
      n_fail++;
      $display("[TB] FAIL b2b_acc0 got rdy=%b we=%b adr=%h want 0 1 %h", req_ready, sram_we, sram_adr, a / 4);
    end
    req_we = 1'b0;
    @(posedge clk); #1;
    n_cmp++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b1) begin
      n_fail++;
      $display("[TB] FAIL b2b_resp got rdy=%b v=%b want 0 1", req_ready, rsp_valid);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (req_ready !== 1'b1 || sram_me !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL b2b_idle got rdy=%b me=%b want 1 0", req_ready, sram_me);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    n_cmp++;
    if (sram_me !== 1'b1 || sram_we !== 1'b0 || req_ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL b2b_second_accept got me=%b we=%b rdy=%b want 1 0 0", sram_me, sram_we, req_ready);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (rsp_valid !== 1'b1 || rsp_rdata !== exp_rd) begin
      n_fail++;
      $display("[TB] FAIL b2b_load got v=%b rd=%h want 1 %h", rsp_valid, rsp_rdata, exp_rd);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic        we   = 1'($urandom);
      logic [1:0]  sz   = 2'($urandom);
      logic        uns  = 1'($urandom);
      logic [AW-1:0] ad = AW'($urandom);
      logic [63:0] wd   = {$urandom, $urandom};
      bit          e_err = ref_misaligned(int'(sz), int'(ad));
      int          e_lat = ref_latency(int'(sz), e_err);
      logic [63:0] e_rd = 64'h0;
      if (!we && !e_err) e_rd = ref_load(int'(sz), int'(ad), uns);
      do_req(we, sz, uns, ad, wd);
      if (we && !e_err) ref_store(int'(sz), int'(ad), wd);
      n_cmp++;
      if (got_err !== e_err || lat != e_lat || got_rdata !== e_rd || seen_me !== !e_err) begin
        n_fail++;
        $display("[TB] FAIL rand%0d we=%b sz=%0d a=%h got err=%b lat=%0d rd=%h me=%b want %b %0d %h %b",
                 n, we, sz, ad, got_err, lat, got_rdata, seen_me, e_err, e_lat, e_rd, !e_err);
      end
    end
  endtask

  initial begin
    req_valid = 1'b0; req_we = 1'b0; req_size = 2'd0; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0; sram_q = 32'h0;
    for (int w = 0; w < NWORDS; w++) begin
      mem[w] = $urandom;
      for (int b = 0; b < 4; b++) ref_mem[4*w+b] = mem[w][8*b +: 8];
    end
    test_reset();
    test_byte();
    test_dword();
    test_word_sign();
    test_misaligned();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
